// File: rtl/commu_txn_if.sv
// Packer-to-transmitter byte stream: one framed packet per pk_frm high period.
interface commu_txn_if;
  logic [7:0] pk_data;
  logic       pk_vld;
  logic       pk_frm;

  modport master (output pk_data, output pk_vld, output pk_frm);
  modport slave  (input  pk_data, input  pk_vld, input  pk_frm);
endinterface

// File: rtl/commu_txn.sv
// Buffers whole packets from the packer and broadcasts each committed packet
// as 8N1 UART on NCH RS-485 channels with guard-timed driver enables.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no committed bytes pending, de low, tx idle high
// LEAD  | de high, tx high for GUARD bit-times before the first start bit
// START | start bit (tx low), byte fetched and rd_ptr advanced on entry
// DATA  | 8 data bits, LSB first
// STOP  | stop bit; chains to START while committed bytes remain
// TRAIL | de still high, tx high for GUARD bit-times, then IDLE
module commu_txn #(
  parameter int NCH      = 2,
  parameter int DEPTH    = 2048,
  parameter int BAUD_DIV = 16,
  parameter int GUARD    = 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  commu_txn_if.slave       pk,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   tx,
  output logic [NCH-1:0]   de,
  output logic             busy,
  output logic             pkt_drop,
  output logic [15:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(GUARD + 8);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_TRAIL = 3'd5;

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [TW-1:0] TMR_ONE  = 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] GRD_LOAD = CW'(GUARD - 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(7);

  logic [7:0]     mem [DEPTH];
  logic [AW:0]    wr_ptr, commit_ptr, rd_ptr;
  logic           frm_q, poison;
  logic           full, wr_en, pend;

  logic [2:0]     state;
  logic [TW-1:0]  tmr;
  logic [CW-1:0]  bcnt;
  logic [7:0]     shreg;
  logic [NCH-1:0] en_q;
  logic           line;

  // Extra pointer MSB differs and the index bits match: exactly DEPTH bytes held.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = !rst && pk.pk_frm && pk.pk_vld && !poison && !full;
  assign pend  = (rd_ptr != commit_ptr);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frm_q      <= 1'b0;
      poison     <= 1'b0;
      pkt_drop   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frm_q    <= pk.pk_frm;
      pkt_drop <= 1'b0;
      if (pk.pk_frm && pk.pk_vld && !poison) begin
        if (full) begin
          poison <= 1'b1;
          wr_ptr <= commit_ptr;
        end else begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
      end
      if (!pk.pk_frm && frm_q) begin
        if (poison) begin
          poison   <= 1'b0;
          pkt_drop <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          commit_ptr <= wr_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= pk.pk_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state  <= S_IDLE;
      tmr    <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      en_q   <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend) begin
            state <= S_LEAD;
            en_q  <= ch_en;
            tmr   <= TMR_LOAD;
            bcnt  <= GRD_LOAD;
          end
        end
        S_LEAD, S_TRAIL: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else if (bcnt != '0) begin
            tmr  <= TMR_LOAD;
            bcnt <= bcnt - CNT_ONE;
          end else if (state == S_TRAIL) begin
            state <= S_IDLE;
          end else begin
            state  <= S_START;
            tmr    <= TMR_LOAD;
            shreg  <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
          end
        end
        S_START: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else begin
            state <= S_DATA;
            tmr   <= TMR_LOAD;
            bcnt  <= BIT_LOAD;
          end
        end
        S_DATA: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else if (bcnt != '0) begin
            tmr   <= TMR_LOAD;
            bcnt  <= bcnt - CNT_ONE;
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            state <= S_STOP;
            tmr   <= TMR_LOAD;
          end
        end
        S_STOP: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else if (pend) begin
            state  <= S_START;
            tmr    <= TMR_LOAD;
            shreg  <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
          end else begin
            state <= S_TRAIL;
            tmr   <= TMR_LOAD;
            bcnt  <= GRD_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    line = 1'b1;
    if (state == S_START) line = 1'b0;
    else if (state == S_DATA) line = shreg[0];
  end

  // Masked channels stay idle high with their drivers off.
  assign busy = (state != S_IDLE);
  assign de   = busy ? en_q : '0;
  assign tx   = ~en_q | {NCH{line}};

endmodule

// File: tb/tb_commu_txn.sv
// Directed bench for commu_txn: checks burst framing, buffering, overflow
// drop, channel masking and mid-burst reset with NCH=2, DEPTH=16, BAUD_DIV=4.
module tb_commu_txn;
  localparam int NCH      = 2;
  localparam int DEPTH    = 16;
  localparam int BAUD_DIV = 4;
  localparam int GUARD    = 1;

  typedef logic [7:0] bq_t[$];

  logic           clk_sys = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] tx;
  logic [NCH-1:0] de;
  logic           busy;
  logic           pkt_drop;
  logic [15:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  commu_txn_if pk_if ();

  commu_txn #(
    .NCH(NCH), .DEPTH(DEPTH), .BAUD_DIV(BAUD_DIV), .GUARD(GUARD)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .pk      (pk_if),
    .ch_en   (ch_en),
    .tx      (tx),
    .de      (de),
    .busy    (busy),
    .pkt_drop(pkt_drop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves pk_frm low at the negedge after the last byte.
  task automatic send_pkt(input bq_t b);
    pk_if.pk_frm = 1'b1;
    foreach (b[i]) begin
      pk_if.pk_data = b[i];
      pk_if.pk_vld  = 1'b1;
      @(negedge clk_sys);
    end
    pk_if.pk_vld = 1'b0;
    pk_if.pk_frm = 1'b0;
  endtask

  // Follows one burst from de rise to de fall against a bit-level line model.
  task automatic watch_burst(input string tag, input bq_t b, input int exp_len,
                             input logic [NCH-1:0] en, input int chg_at,
                             input logic [NCH-1:0] chg_val);
    int k, bad, bt, j, r, w;
    logic line;
    logic [7:0] cur;
    logic [NCH-1:0] etx;
    k = 0; bad = 0; w = 0;
    while (!busy && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    check({tag, "_busy_start"}, busy, 1);
    while (busy && k < exp_len + 50) begin
      if (k == chg_at) ch_en = chg_val;
      bt = k / BAUD_DIV;
      line = 1'b1;
      if (bt >= GUARD) begin
        j = (bt - GUARD) / 10;
        r = (bt - GUARD) % 10;
        if (j < b.size()) begin
          cur = b[j];
          if (r == 0) line = 1'b0;
          else if (r <= 8) line = cur[r-1];
        end
      end
      for (int i = 0; i < NCH; i++) etx[i] = en[i] ? line : 1'b1;
      if (de !== en || tx !== etx) bad++;
      @(negedge clk_sys);
      k++;
    end
    check({tag, "_burst_len"}, k, exp_len);
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_de_after"}, de, 0);
  endtask

  initial begin
    bq_t big, pkt16;
    int drops, busy_seen, w;

    rst = 1'b1;
    ch_en = 2'b11;
    pk_if.pk_frm = 1'b0;
    pk_if.pk_vld = 1'b0;
    pk_if.pk_data = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_tx", tx, 2'b11);
    check("rst_de", de, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_pkt_drop", pkt_drop, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    @(negedge clk_sys);

    // 1: single byte, de rises two cycles after the frame falls
    send_pkt('{8'hA5});
    @(negedge clk_sys);
    check("t1_busy_pre", busy, 0);
    @(negedge clk_sys);
    check("t1_de_rise", de, 2'b11);
    watch_burst("t1", '{8'hA5}, 48, 2'b11, -1, 2'b11);

    // 2: three bytes back-to-back
    send_pkt('{8'h01, 8'h02, 8'h03});
    watch_burst("t2", '{8'h01, 8'h02, 8'h03}, 128, 2'b11, -1, 2'b11);

    // 3: overflow drop, then a packet that exactly fills the buffer
    for (int i = 0; i < 17; i++) big.push_back(8'(i + 8'h40));
    send_pkt(big);
    drops = 0; busy_seen = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (pkt_drop) drops++;
      if (busy || de != 2'b00) busy_seen++;
    end
    check("t3_drop_pulses", drops, 1);
    check("t3_drop_cnt", drop_cnt, 1);
    check("t3_no_burst", busy_seen, 0);
    for (int i = 0; i < 16; i++) pkt16.push_back(8'(i * 17));
    send_pkt(pkt16);
    watch_burst("t3_full16", pkt16, 648, 2'b11, -1, 2'b11);

    // 4: mask latched at burst start; next burst uses the new mask
    ch_en = 2'b01;
    send_pkt('{8'h3C});
    watch_burst("t4a", '{8'h3C}, 48, 2'b01, 20, 2'b10);
    send_pkt('{8'h81});
    watch_burst("t4b", '{8'h81}, 48, 2'b10, -1, 2'b10);

    // 5: reset in the data bits of the second of three bytes
    ch_en = 2'b11;
    send_pkt('{8'h11, 8'h22, 8'h33});
    w = 0;
    while (!busy && w < 200) begin
      @(negedge clk_sys);
      w++;
    end
    check("t5_busy_start", busy, 1);
    repeat (60) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    check("t5_rst_tx", tx, 2'b11);
    check("t5_rst_de", de, 2'b00);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (busy) busy_seen++;
    end
    check("t5_discarded", busy_seen, 0);
    send_pkt('{8'h5A});
    watch_burst("t5_new", '{8'h5A}, 48, 2'b11, -1, 2'b11);

    // 6: empty frame
    pk_if.pk_frm = 1'b1;
    pk_if.pk_vld = 1'b0;
    repeat (5) @(negedge clk_sys);
    pk_if.pk_frm = 1'b0;
    drops = 0; busy_seen = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (pkt_drop) drops++;
      if (busy) busy_seen++;
    end
    check("t6_no_drop", drops, 0);
    check("t6_no_burst", busy_seen, 0);
    check("t6_drop_cnt", drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
